// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the HC-SR04 ranger: FSM state encoding,
// result/width sizing and the quotient-to-distance saturation helper.
package ultrasonic_pkg;

  localparam int DIST_W    = 9;
  localparam int WIDTH_W   = 21;
  localparam int DIVISOR_W = 12;
  localparam logic [DIST_W-1:0] DIST_SAT = 9'h1FF;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DIVIDE,
    TO,
    HOLDOFF
  } state_t;

  function automatic logic [DIST_W-1:0] saturate_dist(input logic [WIDTH_W-1:0] q);
    return (q > WIDTH_W'(DIST_SAT)) ? DIST_SAT : q[DIST_W-1:0];
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_serial_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses exactly
// WIDTH_W cycles after start, with the quotient held until the next start.
module serial_divider
  import ultrasonic_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH_W-1:0]   dividend,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH_W-1:0]   quotient
);

  localparam logic [4:0] ITERATIONS = 5'(WIDTH_W);

  logic [DIVISOR_W-1:0] rem_reg;
  logic [DIVISOR_W-1:0] divisor_reg;
  logic [4:0]           count_reg;
  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W:0]   trial;

  // The dividend is shifted out of the quotient register MSB-first while
  // quotient bits shift in at the bottom; a negative trial means "restore".
  always_comb begin
    shifted = {rem_reg, quotient[WIDTH_W-1]};
    trial   = shifted - {1'b0, divisor_reg};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_reg     <= '0;
      divisor_reg <= '0;
      count_reg   <= '0;
      quotient    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_reg     <= '0;
        divisor_reg <= divisor;
        quotient    <= dividend;
        count_reg   <= ITERATIONS;
        busy        <= 1'b1;
      end else if (busy) begin
        if (!trial[DIVISOR_W]) begin
          rem_reg  <= trial[DIVISOR_W-1:0];
          quotient <= {quotient[WIDTH_W-2:0], 1'b1};
        end else begin
          rem_reg  <= shifted[DIVISOR_W-1:0];
          quotient <= {quotient[WIDTH_W-2:0], 1'b0};
        end
        count_reg <= count_reg - 1'b1;
        if (count_reg == 5'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 measurement sequencer: trigger, echo timing, width-to-cm division.
// Define RANGE_AVG_EN to report a running mean of the last 4 good samples.
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 60,
  parameter int TIMEOUT_US = 30000,
  parameter int US_PER_CM  = 58
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              echo,
  output logic              trig,
  output logic              busy,
  output logic [DIST_W-1:0] distance_cm,
  output logic              timeout,
  output logic              valid
);

  localparam int TRIG_T = CLK_HZ / 1_000_000 * TRIG_US;
  localparam int PER_T  = CLK_HZ / 1_000 * PERIOD_MS;
  localparam int TO_T   = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int DIV    = CLK_HZ / 1_000_000 * US_PER_CM;
  localparam int PER_W  = $clog2(PER_T + 1);

  if (TO_T >= (1 << WIDTH_W) || DIV >= (1 << DIVISOR_W)) begin : g_param_check
    $error("ultrasonic_ranger: TO_T or DIV does not fit its counter");
  end

  state_t             state_reg;
  logic [WIDTH_W-1:0] cnt_reg;
  logic [PER_W-1:0]   per_cnt_reg;
  logic               div_start_reg;
  logic               echo_meta_reg;
  logic               echo_sync_reg;
  logic               echo_prev_reg;
  logic               echo_rise;
  logic               echo_fall;
  logic               div_busy;
  logic               div_done;
  logic [WIDTH_W-1:0] div_quotient;
  logic               sample_done;
  logic [DIST_W-1:0]  raw_dist;
  logic [DIST_W-1:0]  result_dist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_meta_reg <= 1'b0;
      echo_sync_reg <= 1'b0;
      echo_prev_reg <= 1'b0;
    end else begin
      echo_meta_reg <= echo;
      echo_sync_reg <= echo_meta_reg;
      echo_prev_reg <= echo_sync_reg;
    end
  end

  assign echo_rise = echo_sync_reg & ~echo_prev_reg;
  assign echo_fall = ~echo_sync_reg & echo_prev_reg;

  serial_divider u_divider (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start_reg),
    .dividend (cnt_reg),
    .divisor  (DIVISOR_W'(DIV)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  assign sample_done = (state_reg == DIVIDE) && div_done && !div_busy;
  assign raw_dist    = saturate_dist(div_quotient);

`ifdef RANGE_AVG_EN
  logic [DIST_W-1:0] hist_reg [4];
  logic              hist_full_reg;
  logic [DIST_W+1:0] hist_sum;

  // Until the first sample lands, the buffer is treated as four copies of it.
  always_comb begin
    if (hist_full_reg)
      hist_sum = (DIST_W+2)'(raw_dist) + (DIST_W+2)'(hist_reg[0]) +
                 (DIST_W+2)'(hist_reg[1]) + (DIST_W+2)'(hist_reg[2]);
    else
      hist_sum = {raw_dist, 2'b00};
  end
  assign result_dist = hist_sum[DIST_W+1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_reg[0]   <= '0;
      hist_full_reg <= 1'b0;
    end else if (sample_done) begin
      hist_reg[0]   <= raw_dist;
      hist_full_reg <= 1'b1;
    end
  end

  for (genvar gi = 1; gi < 4; gi++) begin : g_hist
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        hist_reg[gi] <= '0;
      else if (sample_done)
        hist_reg[gi] <= hist_full_reg ? hist_reg[gi-1] : raw_dist;
    end
  end
`else
  assign result_dist = raw_dist;
`endif

  // per_cnt_reg runs from every TRIG entry and saturates, so HOLDOFF only has
  // to wait for it to reach the period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      per_cnt_reg   <= '0;
      div_start_reg <= 1'b0;
      trig          <= 1'b0;
      busy          <= 1'b0;
      distance_cm   <= '0;
      timeout       <= 1'b0;
      valid         <= 1'b0;
    end else begin
      valid         <= 1'b0;
      div_start_reg <= 1'b0;
      if (per_cnt_reg < PER_W'(PER_T))
        per_cnt_reg <= per_cnt_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg   <= TRIG;
            trig        <= 1'b1;
            busy        <= 1'b1;
            cnt_reg     <= '0;
            per_cnt_reg <= '0;
          end
        end
        TRIG: begin
          if (cnt_reg == WIDTH_W'(TRIG_T - 1)) begin
            state_reg <= WAIT_RISE;
            trig      <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            state_reg <= MEASURE;
            cnt_reg   <= '0;
          end else if (cnt_reg == WIDTH_W'(TO_T - 1)) begin
            state_reg <= TO;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        MEASURE: begin
          // The fall cycle is counted too, so the width equals the echo high time.
          cnt_reg <= cnt_reg + 1'b1;
          if (echo_fall) begin
            state_reg     <= DIVIDE;
            div_start_reg <= 1'b1;
          end else if (cnt_reg == WIDTH_W'(TO_T - 1)) begin
            state_reg <= TO;
          end
        end
        DIVIDE: begin
          if (sample_done) begin
            distance_cm <= result_dist;
            timeout     <= 1'b0;
            valid       <= 1'b1;
            state_reg   <= HOLDOFF;
          end
        end
        TO: begin
          distance_cm <= DIST_SAT;
          timeout     <= 1'b1;
          valid       <= 1'b1;
          state_reg   <= HOLDOFF;
        end
        HOLDOFF: begin
          if (per_cnt_reg >= PER_W'(PER_T - 1)) begin
            if (enable) begin
              state_reg   <= TRIG;
              trig        <= 1'b1;
              cnt_reg     <= '0;
              per_cnt_reg <= '0;
            end else begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          trig      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
